// File: rtl/fetch_unit.sv
// Instruction-fetch stage with the IF/ID pipeline register for the in-order RISC-V core.
// Runs a single-outstanding request/valid handshake with instruction memory and handles stall, hold and redirect.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_if,
    input  logic            halt_id,
    input  logic            taken_branch,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d;

    logic            stall_s;
    logic            accept_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] pc_inc_s;

    assign stall_s  = halt_if | halt_id;
    assign accept_s = req_q & imem_valid;
    assign target_s = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign pc_inc_s = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

    // Next-state, PC and IF/ID register update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        tgt_d        = tgt_q;
        hold_instr_d = hold_instr_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;

        if (taken_branch) begin
            if_pc_d    = {XLEN{1'b0}};
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                if (taken_branch) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_FETCH: begin
                if (taken_branch) begin
                    if (accept_s) begin
                        pc_d = target_s;
                    end else begin
                        // the in-flight request must still complete before redirecting
                        tgt_d   = target_s;
                        state_d = S_DROP;
                    end
                end else if (accept_s) begin
                    if (stall_s) begin
                        hold_instr_d = imem_rdata;
                        req_d        = 1'b0;
                        state_d      = S_HOLD;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc_s;
                    end
                end else if (!stall_s) begin
                    if_instr_d = NOP_INSTR;
                    if_valid_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (accept_s) begin
                    pc_d    = taken_branch ? target_s : tgt_q;
                    state_d = S_FETCH;
                end else if (taken_branch) begin
                    tgt_d = target_s;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                // the held word belongs to pc_q, which was not advanced on entry
                if (taken_branch) begin
                    pc_d    = target_s;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (!stall_s) begin
                    if_pc_d    = pc_q;
                    if_instr_d = hold_instr_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc_s;
                    req_d      = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            tgt_q        <= {XLEN{1'b0}};
            hold_instr_q <= {XLEN{1'b0}};
            if_pc_q      <= {XLEN{1'b0}};
            if_instr_q   <= NOP_INSTR;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            tgt_q        <= tgt_d;
            hold_instr_q <= hold_instr_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_valid = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a variable-latency memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_if, halt_id, taken_branch;
    logic [31:0] branch_target;

    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid;

    logic        req_b, valid_b;
    logic [31:0] addr_b, rdata_b;
    logic [31:0] pc_b, instr_b;
    logic        ivalid_b;

    int lat;
    int cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit u0 (
        .clk(clk), .rst(rst), .halt_if(halt_if), .halt_id(halt_id),
        .taken_branch(taken_branch), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst), .halt_if(halt_if), .halt_id(halt_id),
        .taken_branch(taken_branch), .branch_target(branch_target),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .imem_valid(valid_b), .if_id_pc(pc_b), .if_id_instr(instr_b),
        .if_id_valid(ivalid_b)
    );

    // Memory responder: answers after lat waiting cycles, data = addr ^ A5
    assign imem_valid = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr ^ 32'h0000_00A5;
    assign valid_b    = req_b;
    assign rdata_b    = addr_b ^ 32'h0000_00A5;

    // Wait-cycle counter for the latency responder
    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_valid) cnt <= 0;
        else                                cnt <= cnt + 1;
    end

    typedef struct {
        int          lat;
        logic        hif, hid, br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr, pc, instr;
        logic        valid;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int l, input logic hif, input logic hid, input logic br,
                       input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                       input logic [31:0] pc, input logic [31:0] instr, input logic valid);
        vec_t v;
        v.lat = l; v.hif = hif; v.hid = hid; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.pc = pc; v.instr = instr; v.valid = valid;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_u0(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] pc, input logic [31:0] instr, input logic valid);
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".pc"},    if_id_pc,             pc);
        chk({tag, ".instr"}, if_id_instr,          instr);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic chk_u1(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] pc, input logic [31:0] instr, input logic valid);
        chk({tag, ".req"},   {31'd0, req_b},    {31'd0, req});
        chk({tag, ".addr"},  addr_b,            addr);
        chk({tag, ".pc"},    pc_b,              pc);
        chk({tag, ".instr"}, instr_b,           instr);
        chk({tag, ".valid"}, {31'd0, ivalid_b}, {31'd0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // zero-latency stream, stall/hold, branch+stall in FETCH and in HOLD
        add(0,0,0,0,32'h0,   1,32'h000,32'h000,32'h013,0);
        add(0,0,0,0,32'h0,   1,32'h004,32'h000,32'h0A5,1);
        add(0,0,0,0,32'h0,   1,32'h008,32'h004,32'h0A1,1);
        add(0,0,0,0,32'h0,   1,32'h00C,32'h008,32'h0AD,1);
        add(0,0,0,0,32'h0,   1,32'h010,32'h00C,32'h0A9,1);
        add(0,1,0,0,32'h0,   0,32'h010,32'h00C,32'h0A9,1);
        add(0,1,0,0,32'h0,   0,32'h010,32'h00C,32'h0A9,1);
        add(0,0,1,0,32'h0,   0,32'h010,32'h00C,32'h0A9,1);
        add(0,0,0,0,32'h0,   1,32'h014,32'h010,32'h0B5,1);
        add(0,0,0,0,32'h0,   1,32'h018,32'h014,32'h0B1,1);
        add(0,0,1,1,32'h80,  1,32'h080,32'h000,32'h013,0);
        add(0,0,0,0,32'h0,   1,32'h084,32'h080,32'h025,1);
        add(0,1,0,0,32'h0,   0,32'h084,32'h080,32'h025,1);
        add(0,0,1,1,32'h103, 1,32'h100,32'h000,32'h013,0);
        add(0,0,0,0,32'h0,   1,32'h104,32'h100,32'h1A5,1);
        // three-cycle latency: bubbles while waiting, address stable
        for (int k = 0; k < 3; k++) add(3,0,0,0,32'h0, 1,32'h104,32'h100,32'h013,0);
        add(3,0,0,0,32'h0,   1,32'h108,32'h104,32'h1A1,1);
        for (int k = 0; k < 3; k++) add(3,0,0,0,32'h0, 1,32'h108,32'h104,32'h013,0);
        add(3,0,0,0,32'h0,   1,32'h10C,32'h108,32'h1AD,1);
        // branch while 0x10C outstanding, retargeted in DROP
        add(3,0,0,1,32'h400, 1,32'h10C,32'h000,32'h013,0);
        add(3,0,0,1,32'h200, 1,32'h10C,32'h000,32'h013,0);
        add(3,0,0,0,32'h0,   1,32'h10C,32'h000,32'h013,0);
        add(3,0,0,0,32'h0,   1,32'h200,32'h000,32'h013,0);
        for (int k = 0; k < 3; k++) add(3,0,0,0,32'h0, 1,32'h200,32'h000,32'h013,0);
        add(3,0,0,0,32'h0,   1,32'h204,32'h200,32'h2A5,1);

        rst = 1'b1; halt_if = 1'b0; halt_id = 1'b0; taken_branch = 1'b0;
        branch_target = 32'h0; lat = 0;
        step();
        step();
        chk_u0("reset", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
        chk("reset.u1addr", addr_b, 32'hFFFF_FFF8);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            lat = vq[i].lat; halt_if = vq[i].hif; halt_id = vq[i].hid;
            taken_branch = vq[i].br; branch_target = vq[i].tgt;
            step();
            chk_u0($sformatf("v%0d", i), vq[i].req, vq[i].addr, vq[i].pc, vq[i].instr, vq[i].valid);
        end

        // enter DROP, then reset mid-operation
        taken_branch = 1'b1; branch_target = 32'h40;
        step();
        chk_u0("drop", 1'b1, 32'h204, 32'h0, 32'h13, 1'b0);
        taken_branch = 1'b0; rst = 1'b1;
        step();
        chk_u0("midrst", 1'b0, 32'h0, 32'h0, 32'h13, 1'b0);
        chk_u1("midrst_b", 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h13, 1'b0);

        // restart: wrap through 0 on the second instance
        rst = 1'b0; lat = 0;
        step();
        chk_u0("restart", 1'b1, 32'h0, 32'h0, 32'h13, 1'b0);
        chk_u1("wrap0", 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h13, 1'b0);
        step();
        chk_u1("wrap1", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FF5D, 1'b1);
        step();
        chk_u1("wrap2", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FF59, 1'b1);
        step();
        chk_u1("wrap3", 1'b1, 32'h4, 32'h0, 32'hA5, 1'b1);
        chk_u0("restart3", 1'b1, 32'hC, 32'h8, 32'hAD, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the in-order RISC-V core.
- Generates the PC, runs a variable-latency request/valid handshake with instruction memory, and delivers (pc, instr, valid) to decode.
- Consumes the hazard unit's halt_if/halt_id stall bits and the execute stage's branch redirect.
- Holds, bubbles or flushes the IF/ID register accordingly.

Parameters:
XLEN, 32, data/address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on bubble/flush.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
halt_if  in  1  stall request for fetch (hazard unit).
halt_id  in  1  stall request for decode; treated identically to halt_if (stall = halt_if | halt_id).
taken_branch  in  1  redirect pulse from execute; valid for one cycle.
branch_target  in  XLEN  redirect address; bits [1:0] ignored (forced 00).
imem_req  out  1  fetch request, registered.
imem_addr  out  XLEN  fetch address, registered; equals internal pc.
imem_rdata  in  XLEN  instruction word, valid when imem_valid=1.
imem_valid  in  1  response strobe; latency ≥0 cycles after imem_req seen high.
if_id_pc  out  XLEN  PC of instruction in IF/ID.
if_id_instr  out  XLEN  instruction in IF/ID.
if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
Reset and memory protocol
- Reset (rst=1 at edge, wins over everything): pc=RESET_PC, state=IDLE, imem_req=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, hold buffer empty.
- imem protocol: once imem_req=1, imem_addr stays stable until the cycle imem_valid=1. At most one outstanding request. imem_valid while imem_req=0 is ignored.
- "Accept" = imem_req & imem_valid in the same cycle.

State transitions (all on the clock edge)
- IDLE: next edge -> FETCH with imem_req=1, imem_addr=pc.
- FETCH, accept, taken_branch=0, stall=0: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay FETCH; imem_req stays 1 (back-to-back, 1 instr/cycle at zero latency).
- FETCH, accept, stall=1, taken_branch=0: imem_rdata -> hold buffer (pc+data); IF/ID unchanged; imem_req <= 0; -> HOLD.
- FETCH, no accept, stall=0: IF/ID <= bubble {pc unchanged, NOP_INSTR, 0}; stay FETCH.
- FETCH, no accept, stall=1: IF/ID unchanged.
- FETCH, taken_branch=1 with accept: response discarded; pc <= target; imem_addr <= target; stay FETCH.
- FETCH, taken_branch=1 without accept: latch target; -> DROP (request must complete).
- DROP: imem_req held at old address. On accept, response discarded, pc <= latched target, -> FETCH. A second taken_branch in DROP overwrites the latched target.
- HOLD: imem_req=0.
  - stall=1: hold unchanged.
  - stall=0: IF/ID <= hold buffer (valid=1); pc <= pc+4; imem_req <= 1; -> FETCH.
  - taken_branch: discard buffer; pc <= target; -> FETCH.

Flush and arithmetic rules
- Flush: taken_branch=1 forces IF/ID <= {0, NOP_INSTR, 0} on that edge in every state. Flush beats stall.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). No misalignment trap.
- Outputs change only on clock edges; no combinational path from inputs to outputs.

Test Plan:
- Reset + stream, zero-latency imem (imem_valid tied to imem_req, rdata=addr^32'hA5): release rst → imem_addr 0,4,8,... each cycle; if_id_pc lags imem_addr by one cycle with if_id_valid=1; instr=pc^A5.
- 3-cycle memory latency: for each request, if_id_valid=1 only one cycle after accept, with NOP_INSTR/valid=0 bubbles otherwise; addr stable during wait.
- Stall mid-stream: halt_if=1 on the cycle of accept at pc=0x10 for 3 cycles → IF/ID frozen at pc=0xC; imem_req=0 during HOLD; on release, IF/ID=pc 0x10 next edge, fetch resumes at 0x14; no instruction lost or duplicated.
- Branch during outstanding request: taken_branch, target 0x200, while waiting on 0x20 → IF/ID flushed (valid=0); 0x20 response discarded; next imem_addr=0x200; first valid IF/ID pc=0x200.
- Branch and stall same cycle: halt_id=1 and taken_branch=1, target 0x80 → IF/ID=NOP/valid=0; HOLD buffer dropped; fetch at 0x80.
- Wrap and reset mid-op: RESET_PC=32'hFFFF_FFF8 → addrs FFFF_FFF8, FFFF_FFFC, 0; assert rst during DROP → all outputs return to reset values next edge, restart at RESET_PC.
